// File: rtl/gpr_sb_regfile.sv
// gpr_sb_regfile: general-purpose register file for the pipelined core.
// It has two combinational read ports, one writeback write port and one
// decode issue port. Each entry carries a pending (scoreboard) bit, and a
// post-reset sweep clears the data array one entry per cycle.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_ni         synchronous active-low reset
//   init_busy_o    high while in reset or while the clear sweep is running
//   ra1_i, ra2_i   read addresses
//   rd1_o, rd2_o   read data (combinational, with optional write bypass)
//   rp1_o, rp2_o   pending bit of ra1_i / ra2_i (combinational)
//   iss_valid_i    marks iss_addr_i pending at the next edge
//   iss_addr_i     destination register of the issued instruction
//   we_i           writeback write enable
//   wa_i, wd_i     write address and write data
//   pc_i           PC of the writing instruction (trace only)
//   trace_*_o      trace strobe for each accepted write (TRACE=1); pc is pc_i-4
module gpr_sb_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          TRACE    = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              init_busy_o,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  output logic              rp1_o,
  output logic              rp2_o,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [31:0]       pc_i,
  output logic              trace_valid_o,
  output logic [31:0]       trace_pc_o,
  output logic [ADDR_W-1:0] trace_wa_o,
  output logic [DATA_W-1:0] trace_wd_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic ready;     // array contents and pending bits are architecturally visible
  logic sweep_we;  // clear array[idx_q] this cycle
  logic wr_acc;
  logic iss_acc;
  logic hit1, hit2;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StInit;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM: next state. The index is compared before incrementing, so it never
  // needs to represent DEPTH and cannot alias past the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StInit: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StReady;
        end
      end
      StReady: ;
      default: state_d = StInit;
    endcase
  end

  // FSM: outputs. init_busy_o comes straight from the state flop.
  always_comb begin
    init_busy_o = (state_q == StInit);
    ready       = (state_q == StReady) && rst_ni;
    sweep_we    = (state_q == StInit) && rst_ni;
  end

  // ---------------------------------------------------------------------------
  // Write / issue acceptance. With ZERO_REG, entry 0 swallows both.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_acc  = ready && we_i && !(ZERO_REG && (wa_i == '0));
    iss_acc = ready && iss_valid_i && !(ZERO_REG && (iss_addr_i == '0));
  end

  // Data array: no reset branch, the sweep clears it after reset release.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      mem_q[idx_q] <= '0;
    end else if (wr_acc) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Pending bits: the issue mark is applied after the write clear so that an
  // issue and a write to the same register on one edge leave it pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_acc) begin
      pend_d[wa_i] = 1'b0;
    end
    if (iss_acc) begin
      pend_d[iss_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. A same-cycle accepted write forwards its data and reports
  // the register as no longer pending, even if it is being re-issued.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit1  = BYPASS && wr_acc && (wa_i == ra1_i);
    hit2  = BYPASS && wr_acc && (wa_i == ra2_i);
    rd1_o = '0;
    rd2_o = '0;
    rp1_o = 1'b0;
    rp2_o = 1'b0;
    if (ready) begin
      rd1_o = hit1 ? wd_i : mem_q[ra1_i];
      rd2_o = hit2 ? wd_i : mem_q[ra2_i];
      rp1_o = hit1 ? 1'b0 : pend_q[ra1_i];
      rp2_o = hit2 ? 1'b0 : pend_q[ra2_i];
      if (ZERO_REG && (ra1_i == '0)) begin
        rd1_o = '0;
        rp1_o = 1'b0;
      end
      if (ZERO_REG && (ra2_i == '0)) begin
        rd2_o = '0;
        rp2_o = 1'b0;
      end
    end
  end

  // Trace hook: one strobe per accepted write, never for dropped $0 writes.
  always_comb begin
    trace_valid_o = TRACE && wr_acc;
    trace_pc_o    = pc_i - 32'd4;
    trace_wa_o    = wa_i;
    trace_wd_o    = wd_i;
  end

endmodule

// File: tb/tb_gpr_sb_regfile.sv
module tb_gpr_sb_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              init_busy_o;
  logic [ADDR_W-1:0] ra1_i, ra2_i, iss_addr_i, wa_i;
  logic [DATA_W-1:0] rd1_o, rd2_o, wd_i;
  logic              rp1_o, rp2_o, iss_valid_i, we_i;
  logic [31:0]       pc_i;
  logic              trace_valid_o;
  logic [31:0]       trace_pc_o;
  logic [ADDR_W-1:0] trace_wa_o;
  logic [DATA_W-1:0] trace_wd_o;

  int num_checks = 0;
  int num_bad    = 0;
  int n;

  gpr_sb_regfile #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1'b1),
    .BYPASS  (1'b1),
    .TRACE   (1'b1)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .init_busy_o  (init_busy_o),
    .ra1_i        (ra1_i),
    .ra2_i        (ra2_i),
    .rd1_o        (rd1_o),
    .rd2_o        (rd2_o),
    .rp1_o        (rp1_o),
    .rp2_o        (rp2_o),
    .iss_valid_i  (iss_valid_i),
    .iss_addr_i   (iss_addr_i),
    .we_i         (we_i),
    .wa_i         (wa_i),
    .wd_i         (wd_i),
    .pc_i         (pc_i),
    .trace_valid_o(trace_valid_o),
    .trace_pc_o   (trace_pc_o),
    .trace_wa_o   (trace_wa_o),
    .trace_wd_o   (trace_wd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Count edges until init_busy_o drops; bounded so a stuck sweep still ends.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (init_busy_o === 1'b1 && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    ra1_i = '0; ra2_i = '0; iss_valid_i = 1'b0; iss_addr_i = '0;
    we_i = 1'b0; wa_i = '0; wd_i = '0; pc_i = 32'h100;

    // 1: reset, then a full DEPTH-cycle sweep.
    repeat (3) step();
    ra1_i = 5'd5;
    #1;
    check("rst_busy", 64'(init_busy_o), 64'd1);
    check("rst_rd1", 64'(rd1_o), 64'd0);
    check("rst_rp1", 64'(rp1_o), 64'd0);
    rst_ni = 1'b1;
    wait_ready(n);
    check("sweep_len", 64'(n), 64'd32);
    ra1_i = 5'd3; ra2_i = 5'd31;
    #1;
    check("clr_rd1", 64'(rd1_o), 64'd0);
    check("clr_rd2", 64'(rd2_o), 64'd0);

    // 2: bypass write to $5, then persistent.
    we_i = 1'b1; wa_i = 5'd5; wd_i = 32'hDEADBEEF; ra1_i = 5'd5;
    #1;
    check("byp_rd1", 64'(rd1_o), 64'hDEADBEEF);
    check("trc_v", 64'(trace_valid_o), 64'd1);
    check("trc_pc", 64'(trace_pc_o), 64'h0FC);
    step();
    we_i = 1'b0;
    #1;
    check("wr_rd1", 64'(rd1_o), 64'hDEADBEEF);

    // 3: $0 ignores writes and issue marks.
    we_i = 1'b1; wa_i = 5'd0; wd_i = 32'h1234; ra1_i = 5'd0;
    #1;
    check("z_trc", 64'(trace_valid_o), 64'd0);
    check("z_byp", 64'(rd1_o), 64'd0);
    step();
    we_i = 1'b0;
    #1;
    check("z_rd1", 64'(rd1_o), 64'd0);
    iss_valid_i = 1'b1; iss_addr_i = 5'd0;
    step();
    iss_valid_i = 1'b0;
    #1;
    check("z_rp1", 64'(rp1_o), 64'd0);

    // 4: issue $7, then writeback clears the pending bit.
    iss_valid_i = 1'b1; iss_addr_i = 5'd7; ra2_i = 5'd7;
    #1;
    check("iss_same", 64'(rp2_o), 64'd0);
    step();
    iss_valid_i = 1'b0;
    #1;
    check("iss_rp2", 64'(rp2_o), 64'd1);
    we_i = 1'b1; wa_i = 5'd7; wd_i = 32'h77;
    #1;
    check("wb_rp2", 64'(rp2_o), 64'd0);
    check("wb_rd2", 64'(rd2_o), 64'h77);
    step();
    we_i = 1'b0;
    #1;
    check("wb_rp2_n", 64'(rp2_o), 64'd0);
    check("wb_rd2_n", 64'(rd2_o), 64'h77);

    // 5: issue and write $9 on the same edge; issue wins.
    iss_valid_i = 1'b1; iss_addr_i = 5'd9; we_i = 1'b1; wa_i = 5'd9; wd_i = 32'hAA55;
    ra1_i = 5'd9;
    #1;
    check("iw_rp1", 64'(rp1_o), 64'd0);
    check("iw_rd1", 64'(rd1_o), 64'hAA55);
    step();
    iss_valid_i = 1'b0; we_i = 1'b0;
    #1;
    check("iw_rp1_n", 64'(rp1_o), 64'd1);
    check("iw_rd1_n", 64'(rd1_o), 64'hAA55);

    // Same address on both ports.
    ra1_i = 5'd5; ra2_i = 5'd5;
    #1;
    check("dual_rd1", 64'(rd1_o), 64'hDEADBEEF);
    check("dual_rd2", 64'(rd2_o), 64'hDEADBEEF);

    // 6: reset during sweep at idx 10 restarts the full sweep.
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    repeat (10) step();
    check("mid_busy", 64'(init_busy_o), 64'd1);
    check("mid_rd1", 64'(rd1_o), 64'd0);
    rst_ni = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    wait_ready(n);
    check("resweep_len", 64'(n), 64'd32);
    ra1_i = 5'd5; ra2_i = 5'd9;
    #1;
    check("rs_rd1", 64'(rd1_o), 64'd0);
    check("rs_rd2", 64'(rd2_o), 64'd0);
    check("rs_rp2", 64'(rp2_o), 64'd0);

    $display("test done: total=%0d bad=%0d", num_checks, num_bad);
    $finish;
  end

endmodule
